terminal_writer: RTL and testbench

Upstream feeder for `character_sprites`. It accepts a stream of ASCII bytes from the keyboard decoder over a valid/ready handshake and maintains a text cursor. It turns each byte into single-cycle writes on the terminal-grid write port (`tg_write_en` / `tg_addr` / `tg_input`). It also handles cursor advance, line wrap, newline, backspace and full-screen clear.

---
 rtl/terminal_writer.sv | 153 +++++++++++++++
 tb/tb_terminal_writer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/terminal_writer.sv
// terminal_writer: turns a handshaked ASCII byte stream into single-cycle
// writes on the terminal-grid port. It tracks a text cursor and handles
// wrap, newline, backspace and a full-screen clear sweep.
module terminal_writer #(
    parameter int SCREEN_WIDTH   = 76,
    parameter int SCREEN_HEIGHT  = 44,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                          pixel_clk_in,
    input  logic                                          rst_in,
    input  logic                                          char_valid_in,
    input  logic [7:0]                                    char_in,
    output logic                                          char_ready_out,
    output logic                                          tg_write_en,
    output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] tg_addr,
    output logic [7:0]                                    tg_input,
    output logic [$clog2(SCREEN_WIDTH)-1:0]               cursor_x_out,
    output logic [$clog2(SCREEN_HEIGHT)-1:0]              cursor_y_out,
    output logic                                          busy_out
);

    localparam int CELLS = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int AW    = $clog2(CELLS);
    localparam int XW    = $clog2(SCREEN_WIDTH);
    localparam int YW    = $clog2(SCREEN_HEIGHT);
    // Sweep index needs one extra code so "all cells written" is representable.
    localparam int IW    = $clog2(CELLS + 1);

    localparam logic [XW-1:0] X_MAX = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_HEIGHT - 1);
    localparam logic [7:0]    SPACE = 8'd32;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state;
    logic [IW-1:0] sweep_idx;
    logic [AW-1:0] cursor_addr;
    logic          accept;

    // Row-major cell address of a grid position.
    function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x,
                                                input logic [YW-1:0] y);
        return AW'(int'(y) * SCREEN_WIDTH + int'(x));
    endfunction

    // Row below the given one, wrapping from the last row back to the top.
    function automatic logic [YW-1:0] next_row(input logic [YW-1:0] y);
        return (y == Y_MAX) ? '0 : y + YW'(1);
    endfunction

    // Bytes that are stored on the grid.
    function automatic logic is_printable(input logic [7:0] c);
        return (c == 8'd32) || (c >= 8'd97 && c <= 8'd122) ||
               (c == 8'd40) || (c == 8'd41) ||
               (c >= 8'd60 && c <= 8'd62);
    endfunction

    assign cursor_addr = cell_addr(cursor_x_out, cursor_y_out);
    assign accept      = char_valid_in && char_ready_out;

    // Control FSM: byte handling in IDLE, one cleared cell per cycle in CLEAR.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            sweep_idx      <= '0;
            char_ready_out <= 1'b0;
            tg_write_en    <= 1'b0;
            tg_addr        <= '0;
            tg_input       <= '0;
            cursor_x_out   <= '0;
            cursor_y_out   <= '0;
            busy_out       <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (sweep_idx < IW'(CELLS)) begin
                        tg_write_en    <= 1'b1;
                        tg_addr        <= AW'(sweep_idx);
                        tg_input       <= SPACE;
                        sweep_idx      <= sweep_idx + IW'(1);
                        busy_out       <= 1'b1;
                        char_ready_out <= 1'b0;
                    end else begin
                        // Every cell written: release the input side.
                        tg_write_en    <= 1'b0;
                        busy_out       <= 1'b0;
                        char_ready_out <= 1'b1;
                        sweep_idx      <= '0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    tg_write_en    <= 1'b0;
                    busy_out       <= 1'b0;
                    char_ready_out <= 1'b1;
                    if (accept) begin
                        if (is_printable(char_in)) begin
                            tg_write_en <= 1'b1;
                            tg_addr     <= cursor_addr;
                            tg_input    <= char_in;
                            if (cursor_x_out == X_MAX) begin
                                cursor_x_out <= '0;
                                cursor_y_out <= next_row(cursor_y_out);
                            end else begin
                                cursor_x_out <= cursor_x_out + XW'(1);
                            end
                        end else begin
                            case (char_in)
                                8'd10, 8'd13: begin
                                    cursor_x_out <= '0;
                                    cursor_y_out <= next_row(cursor_y_out);
                                end
                                8'd8: begin
                                    // Both the in-row and previous-row cases land
                                    // on the cell just before the cursor.
                                    if (cursor_x_out != '0 || cursor_y_out != '0) begin
                                        tg_write_en <= 1'b1;
                                        tg_addr     <= cursor_addr - AW'(1);
                                        tg_input    <= SPACE;
                                        if (cursor_x_out != '0) begin
                                            cursor_x_out <= cursor_x_out - XW'(1);
                                        end else begin
                                            cursor_x_out <= X_MAX;
                                            cursor_y_out <= cursor_y_out - YW'(1);
                                        end
                                    end
                                end
                                8'd12: begin
                                    // Cell 0 is written on this edge; the sweep
                                    // continues from cell 1.
                                    cursor_x_out   <= '0;
                                    cursor_y_out   <= '0;
                                    tg_write_en    <= 1'b1;
                                    tg_addr        <= '0;
                                    tg_input       <= SPACE;
                                    sweep_idx      <= IW'(1);
                                    busy_out       <= 1'b1;
                                    char_ready_out <= 1'b0;
                                    state          <= CLEAR;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_terminal_writer.sv
// tb_terminal_writer: drives directed and random byte streams into
// terminal_writer and compares every output each cycle against a
// cursor/countdown reference model.
module tb_terminal_writer;

    localparam int W  = 76;
    localparam int H  = 44;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          valid = 1'b0;
    logic [7:0]    ch    = 8'd0;
    logic          ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          busy;

    terminal_writer #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .CLEAR_ON_RESET(1)
    ) dut (
        .pixel_clk_in  (clk),
        .rst_in        (rst),
        .char_valid_in (valid),
        .char_in       (ch),
        .char_ready_out(ready),
        .tg_write_en   (we),
        .tg_addr       (addr),
        .tg_input      (data),
        .cursor_x_out  (cx),
        .cursor_y_out  (cy),
        .busy_out      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: cursor as plain integers, a clear sweep as a countdown
    // of cells still to be written.
    int m_we = 0, m_addr = 0, m_data = 0, m_x = 0, m_y = 0;
    int m_busy = 0, m_ready = 0;
    int sweep_left = N;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_we = 0; m_addr = 0; m_data = 0; m_x = 0; m_y = 0;
            m_busy = 0; m_ready = 0;
            sweep_left = N;
        end else begin
            bit acc;
            int c;
            acc  = valid && (m_ready == 1);
            c    = int'(ch);
            m_we = 0;
            if (sweep_left > 0) begin
                m_we = 1; m_addr = N - sweep_left; m_data = 32;
                sweep_left--;
                m_busy = 1; m_ready = 0;
            end else begin
                m_busy = 0; m_ready = 1;
                if (acc) begin
                    if (c inside {32, [97:122], 40, 41, [60:62]}) begin
                        m_we = 1; m_addr = m_y * W + m_x; m_data = c;
                        m_x++;
                        if (m_x == W) begin
                            m_x = 0;
                            m_y = (m_y + 1) % H;
                        end
                    end else if (c == 10 || c == 13) begin
                        m_x = 0;
                        m_y = (m_y + 1) % H;
                    end else if (c == 8) begin
                        if (m_x > 0 || m_y > 0) begin
                            if (m_x > 0) m_x--;
                            else begin
                                m_x = W - 1;
                                m_y--;
                            end
                            m_we = 1; m_addr = m_y * W + m_x; m_data = 32;
                        end
                    end else if (c == 12) begin
                        m_x = 0; m_y = 0;
                        m_we = 1; m_addr = 0; m_data = 32;
                        sweep_left = N - 1;
                        m_busy = 1; m_ready = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("write_en", int'(we), m_we);
        if (m_we == 1) begin
            check("addr", int'(addr), m_addr);
            check("data", int'(data), m_data);
        end
        check("cursor_x", int'(cx), m_x);
        check("cursor_y", int'(cy), m_y);
        check("busy", int'(busy), m_busy);
        check("ready", int'(ready), m_ready);
    end

    // Present one byte and hold it until the DUT takes it; returns on the
    // falling edge after the accepting edge.
    task automatic send(input logic [7:0] c);
        int k;
        bit r;
        ch    = c;
        valid = 1'b1;
        k     = 0;
        forever begin
            r = ready;
            @(negedge clk);
            if (r) break;
            k++;
            if (k > N + 50) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        int k;
        valid = 1'b0;
        k     = 0;
        while (!ready) begin
            @(negedge clk);
            k++;
            if (k > N + 50) begin
                check("ready_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic send_n(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) send(c);
    endtask

    task automatic expect_cursor(input string tag, input int x, input int y);
        check({tag, "_x"}, int'(cx), x);
        check({tag, "_y"}, int'(cy), y);
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        logic [7:0] printable [6];
        printable = '{8'd32, 8'd40, 8'd41, 8'd60, 8'd61, 8'd62};
        r = $urandom_range(0, 19);
        if (r < 8)       return 8'($urandom_range(97, 122));
        else if (r < 10) return printable[$urandom_range(0, 5)];
        else if (r == 10) return 8'd10;
        else if (r == 11) return 8'd13;
        else if (r < 15) return 8'd8;
        else if (r < 17) return 8'($urandom_range(65, 90));
        else if (r < 18) return 8'($urandom_range(128, 255));
        else             return 8'($urandom_range(0, 7));
    endfunction

    initial begin
        // Reset, then the power-on clear sweep.
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        wait_ready();

        // Backspace at the origin: nothing happens.
        send(8'd8);
        expect_cursor("bs_origin", 0, 0);

        // Basic text, back to back.
        send("a"); send("b"); send("c");
        idle_cycles(1);
        expect_cursor("abc", 3, 0);

        // Clear back to the origin, then bottom-right wrap.
        send(8'd12);
        wait_ready();
        send_n(8'd10, H - 1);
        send_n("a", W - 1);
        expect_cursor("pre_wrap", W - 1, H - 1);
        send("z");
        expect_cursor("wrap_last", 0, 0);

        // End-of-row wrap, then backspace across the row boundary.
        send_n("b", W - 1);
        send("x");
        expect_cursor("wrap_row", 0, 1);
        send(8'd8);
        expect_cursor("bs_row", W - 1, 0);

        // Newline at (5,2) and an ignored byte.
        send(8'd10); send(8'd10);
        send_n("c", 5);
        expect_cursor("at_5_2", 5, 2);
        send(8'd13);
        expect_cursor("cr", 0, 3);
        send(8'd65);
        idle_cycles(1);
        expect_cursor("ignored", 0, 3);

        // Form feed with the next byte already waiting.
        send(8'd12);
        send("q");
        valid = 1'b0;
        expect_cursor("after_q", 1, 0);

        // Reset in the middle of a sweep.
        send(8'd12);
        idle_cycles(200);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_we", int'(we), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(ready), 0);
        check("midrst_addr", int'(addr), 0);
        check("midrst_data", int'(data), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_ready();

        // Random traffic with random gaps.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
            else send(pick_byte());
        end
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
